// File: rtl/amadeus_pkg.sv
// -----------------------------------------------------------------------------
// amadeus_pkg
// Shared constants and types for the output-feature-map compression path.
//   MEM_BANDWIDTH : bytes per memory word
//   MEM_ADDR_SIZE : memory byte-address width
//   GROUP_BYTES   : bytes per compression group (8, so the mask is one byte)
//   compress_state_e : states of the compressor FSM
// -----------------------------------------------------------------------------
package amadeus_pkg;

    localparam int MEM_BANDWIDTH = 32;
    localparam int MEM_ADDR_SIZE = 32;
    localparam int GROUP_BYTES   = 8;

    localparam int GROUP_BITS = GROUP_BYTES * 8;
    // Encoded group: one mask byte followed by up to GROUP_BYTES data bytes.
    localparam int ENC_BYTES  = GROUP_BYTES + 1;
    localparam int ENC_BITS   = ENC_BYTES * 8;
    localparam int ENC_LEN_W  = 4;
    localparam int WORD_BITS  = MEM_BANDWIDTH * 8;
    // Two words of staging: fill never exceeds MEM_BANDWIDTH + GROUP_BYTES.
    localparam int BUF_BYTES  = 2 * MEM_BANDWIDTH;
    localparam int BUF_BITS   = BUF_BYTES * 8;
    localparam int FILL_W     = $clog2(BUF_BYTES + 1);

    typedef enum logic [1:0] {
        CS_IDLE,
        CS_RUN,
        CS_FLUSH,
        CS_DONE
    } compress_state_e;

endpackage

// File: rtl/ofmap_compressor_if.sv
// -----------------------------------------------------------------------------
// Bus interfaces of the ofmap compressor.
//
// ofmap_group_if : uncompressed group stream from the psum drain path
//   in_valid / in_ready : handshake, transfer when both are high
//   in_data             : 8-byte group, byte i at in_data[8i+7:8i]
//   in_last             : marks the final group of a layer
//   master = producer, slave = compressor
//
// ofmap_mem_if : memory write port
//   mem_write      : request, held until mem_ack
//   mem_addr       : byte address of the word
//   mem_write_data : word, byte 0 at bits [7:0]
//   mem_ack        : write accepted this cycle
//   master = compressor, slave = memory
// -----------------------------------------------------------------------------
interface ofmap_group_if
    import amadeus_pkg::*;
();
    logic                  in_valid;
    logic [GROUP_BITS-1:0] in_data;
    logic                  in_last;
    logic                  in_ready;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

interface ofmap_mem_if
    import amadeus_pkg::*;
();
    logic                     mem_write;
    logic [MEM_ADDR_SIZE-1:0] mem_addr;
    logic [WORD_BITS-1:0]     mem_write_data;
    logic                     mem_ack;

    modport master (output mem_write, output mem_addr, output mem_write_data, input mem_ack);
    modport slave  (input mem_write, input mem_addr, input mem_write_data, output mem_ack);
endinterface

// File: rtl/ofmap_compressor_group_encoder.sv
// -----------------------------------------------------------------------------
// group_encoder
// Combinational bitmap encoder for one 8-byte group.
//   group_i : raw group, byte i at group_i[8i+7:8i]
//   enc_o   : encoded group; byte 0 is the mask (bit i = byte i non-zero),
//             bytes 1.. are the non-zero bytes in ascending index order,
//             unused upper bytes are zero
//   len_o   : encoded length in bytes, 1..9
// -----------------------------------------------------------------------------
module group_encoder
    import amadeus_pkg::*;
(
    input  logic [GROUP_BITS-1:0] group_i,
    output logic [ENC_BITS-1:0]   enc_o,
    output logic [ENC_LEN_W-1:0]  len_o
);

    always_comb begin : encode
        logic [ENC_LEN_W-1:0] pos;
        // NOTE: every combinationally driven value gets a default before any
        // conditional assignment, so no path leaves it unassigned (no latch).
        enc_o = '0;
        pos   = ENC_LEN_W'(1);
        for (int i = 0; i < GROUP_BYTES; i++) begin
            if (group_i[8*i +: 8] != 8'h00) begin
                enc_o[i]          = 1'b1;
                enc_o[8*pos +: 8] = group_i[8*i +: 8];
                pos               = pos + ENC_LEN_W'(1);
            end
        end
        len_o = pos;
    end

endmodule

// File: rtl/ofmap_compressor.sv
// -----------------------------------------------------------------------------
// ofmap_compressor
// Bitmap-compresses output-feature-map groups and writes the packed stream to
// memory as MEM_BANDWIDTH-byte words at consecutive addresses.
//   clk, rst     : clock, synchronous active-high reset
//   start        : pulse in IDLE begins a layer stream
//   start_addr   : first write address, sampled on start
//   grp          : group stream (slave side)
//   mem          : memory write port (master side)
//   busy         : FSM not idle
//   done         : one-cycle pulse when the whole stream has been written
//   total_bytes  : unpadded compressed byte count, held until the next start
// -----------------------------------------------------------------------------
module ofmap_compressor
    import amadeus_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [MEM_ADDR_SIZE-1:0] start_addr,
    ofmap_group_if.slave             grp,
    ofmap_mem_if.master              mem,
    output logic                     busy,
    output logic                     done,
    output logic [MEM_ADDR_SIZE-1:0] total_bytes
);

    localparam logic [FILL_W-1:0]        BW_FILL = FILL_W'(MEM_BANDWIDTH);
    localparam logic [MEM_ADDR_SIZE-1:0] BW_ADDR = MEM_ADDR_SIZE'(MEM_BANDWIDTH);

    compress_state_e          state_q, state_d;
    logic [FILL_W-1:0]        fill_q, fill_d;
    logic [BUF_BITS-1:0]      pack_q, pack_d;
    logic [MEM_ADDR_SIZE-1:0] addr_q, addr_d;
    logic [MEM_ADDR_SIZE-1:0] total_q, total_d;
    logic                     mem_write_q, mem_write_d;

    logic [ENC_BITS-1:0]      enc;
    logic [ENC_LEN_W-1:0]     enc_len;
    logic                     ready;
    logic                     accept;

    group_encoder u_group_encoder (
        .group_i (grp.in_data),
        .enc_o   (enc),
        .len_o   (enc_len)
    );

    // Accepting only below one word of fill, and never during a write, keeps
    // fill <= MEM_BANDWIDTH + 8 and separates accepts from writes.
    assign ready  = (state_q == CS_RUN) && (fill_q < BW_FILL) && !mem_write_q;
    assign accept = grp.in_valid && ready;

    assign grp.in_ready       = ready;
    assign mem.mem_write      = mem_write_q;
    assign mem.mem_addr       = addr_q;
    // The buffer cannot change while a write is pending, so its low word is
    // stable for the whole request; bytes above fill are always zero, which
    // provides the padding of the final word.
    assign mem.mem_write_data = pack_q[WORD_BITS-1:0];
    assign busy               = (state_q != CS_IDLE);
    assign done               = (state_q == CS_DONE);
    assign total_bytes        = total_q;

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        pack_d      = pack_q;
        addr_d      = addr_q;
        total_d     = total_q;
        mem_write_d = mem_write_q;

        unique case (state_q)
            CS_IDLE: begin
                if (start) begin
                    addr_d  = start_addr;
                    fill_d  = '0;
                    pack_d  = '0;
                    total_d = '0;
                    state_d = CS_RUN;
                end
            end

            CS_RUN, CS_FLUSH: begin
                if (mem_write_q) begin
                    if (mem.mem_ack) begin
                        mem_write_d = 1'b0;
                        pack_d      = pack_q >> WORD_BITS;
                        // A padded final write consumes whatever fill is left.
                        fill_d      = (fill_q >= BW_FILL) ? (fill_q - BW_FILL) : '0;
                        addr_d      = addr_q + BW_ADDR;
                    end
                end else if ((fill_q >= BW_FILL) ||
                             ((state_q == CS_FLUSH) && (fill_q != '0))) begin
                    mem_write_d = 1'b1;
                end else if (accept) begin
                    // Bytes at and above fill are zero, so OR places the group.
                    pack_d  = pack_q | (BUF_BITS'(enc) << {fill_q, 3'b000});
                    fill_d  = fill_q + FILL_W'(enc_len);
                    total_d = total_q + MEM_ADDR_SIZE'(enc_len);
                    if (grp.in_last) begin
                        state_d = CS_FLUSH;
                    end
                end else if (state_q == CS_FLUSH) begin
                    // Buffer empty and nothing outstanding.
                    state_d = CS_DONE;
                end
            end

            CS_DONE: begin
                state_d = CS_IDLE;
            end

            default: begin
                state_d = CS_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CS_IDLE;
            fill_q      <= '0;
            // NOTE: the pack buffer is reset rather than left undefined because
            // appends OR into it and the final word's padding comes from it.
            pack_q      <= '0;
            addr_q      <= '0;
            total_q     <= '0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            pack_q      <= pack_d;
            addr_q      <= addr_d;
            total_q     <= total_d;
            mem_write_q <= mem_write_d;
        end
    end

endmodule

// File: tb/tb_ofmap_compressor.sv
// -----------------------------------------------------------------------------
// tb_ofmap_compressor
// Self-checking bench for ofmap_compressor: a table of single-group streams
// with hand-computed encodings, directed multi-cycle scenarios, and random
// streams compared against a byte-queue reference model.
// -----------------------------------------------------------------------------
module tb_ofmap_compressor;

    localparam int BW = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] start_addr;
    logic        busy;
    logic        done;
    logic [31:0] total_bytes;

    ofmap_group_if grp_bus ();
    ofmap_mem_if   mem_bus ();

    ofmap_compressor dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_addr  (start_addr),
        .grp         (grp_bus),
        .mem         (mem_bus),
        .busy        (busy),
        .done        (done),
        .total_bytes (total_bytes)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ack_delay = 0;
    int done_cnt = 0;

    logic [31:0]  got_addr[$];
    logic [255:0] got_data[$];
    logic [31:0]  exp_addr[$];
    logic [255:0] exp_data[$];
    int           exp_total;
    logic [63:0]  stim_q[$];

    typedef struct {
        logic [63:0] data;
        logic [71:0] enc;
        int          len;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Memory model: acks each request after ack_delay cycles, records it, and
    // checks that the request stays stable while waiting.
    initial begin : responder
        int           wcnt;
        logic [31:0]  h_addr;
        logic [255:0] h_data;
        wcnt = 0;
        h_addr = '0;
        h_data = '0;
        mem_bus.mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_bus.mem_ack) begin
                mem_bus.mem_ack = 1'b0;
            end else if (mem_bus.mem_write === 1'b1) begin
                if (wcnt == 0) begin
                    h_addr = mem_bus.mem_addr;
                    h_data = mem_bus.mem_write_data;
                end else begin
                    check("addr_stable", mem_bus.mem_addr, h_addr);
                    check("data_stable", mem_bus.mem_write_data, h_data);
                end
                if (wcnt >= ack_delay) begin
                    got_addr.push_back(mem_bus.mem_addr);
                    got_data.push_back(mem_bus.mem_write_data);
                    mem_bus.mem_ack = 1'b1;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (mem_bus.mem_write === 1'b1) check("ready_during_write", grp_bus.in_ready, 1'b0);
    end

    // Called at a negedge; returns at the negedge following acceptance.
    task automatic send_group(input logic [63:0] d, input logic l);
        int n;
        n = 0;
        grp_bus.in_valid = 1'b1;
        grp_bus.in_data  = d;
        grp_bus.in_last  = l;
        while (grp_bus.in_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) fail_timeout("accept_timeout");
        @(negedge clk);
        grp_bus.in_valid = 1'b0;
        grp_bus.in_last  = 1'b0;
    endtask

    // Reference: encoded byte stream chopped into zero-padded words.
    task automatic build_model(input logic [31:0] a0);
        logic [7:0] bq[$];
        bq = {};
        exp_addr.delete();
        exp_data.delete();
        foreach (stim_q[k]) begin
            logic [7:0] m;
            logic [7:0] nz[$];
            m = '0;
            nz = {};
            for (int i = 0; i < 8; i++) begin
                if (stim_q[k][8*i +: 8] != 8'h00) begin
                    m[i] = 1'b1;
                    nz.push_back(stim_q[k][8*i +: 8]);
                end
            end
            bq.push_back(m);
            foreach (nz[j]) bq.push_back(nz[j]);
        end
        exp_total = bq.size();
        for (int off = 0; off < bq.size(); off += BW) begin
            logic [255:0] w;
            w = '0;
            for (int j = 0; j < BW; j++) begin
                if (off + j < bq.size()) w[8*j +: 8] = bq[off + j];
            end
            exp_data.push_back(w);
            exp_addr.push_back(a0 + 32'(off));
        end
    endtask

    // Runs stim_q as one layer at a0; if busy_start_at >= 0 a stray start
    // pulse is issued before that group.
    task automatic run_stream(input logic [31:0] a0, input int busy_start_at);
        int n;
        build_model(a0);
        got_addr.delete();
        got_data.delete();
        done_cnt = 0;
        start_addr = a0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < stim_q.size(); k++) begin
            if (k == busy_start_at) begin
                start_addr = 32'h5A5A_0000;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            send_group(stim_q[k], k == stim_q.size() - 1);
        end
        n = 0;
        while (done_cnt == 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == 0) fail_timeout("done_timeout");
        repeat (3) @(negedge clk);
        check("done_pulses", done_cnt, 1);
        check("busy_after_done", busy, 1'b0);
        check("write_count", got_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            check("write_addr", got_addr[i], exp_addr[i]);
            check("write_data", got_data[i], exp_data[i]);
        end
        check("total_bytes", total_bytes, exp_total);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, grp_bus.in_ready, 1'b0);
        check({tag, "_mem_write"}, mem_bus.mem_write, 1'b0);
        check({tag, "_mem_addr"}, mem_bus.mem_addr, 32'h0);
        check({tag, "_mem_data"}, mem_bus.mem_write_data, 256'h0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_total"}, total_bytes, 32'h0);
    endtask

    localparam logic [63:0] PAT = 64'h0807_0605_0403_0201;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        start_addr = '0;
        grp_bus.in_valid = 1'b0;
        grp_bus.in_data  = '0;
        grp_bus.in_last  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single-group streams with hand-computed encodings.
        vecs[0] = '{64'h0000_0000_0000_0000, 72'h00, 1};
        vecs[1] = '{PAT, 72'h08_0706_0504_0302_01FF, 9};
        vecs[2] = '{64'h00BB_0000_0000_AA00, 72'hBB_AA42, 3};
        vecs[3] = '{64'h8000_0000_0000_0000, 72'h80_80, 2};
        vecs[4] = '{64'h0000_0000_0000_00FF, 72'hFF_01, 2};
        vecs[5] = '{64'h1100_2200_3300_4400, 72'h11_2233_44AA, 5};
        for (int i = 0; i < 6; i++) begin
            stim_q = {};
            stim_q.push_back(vecs[i].data);
            ack_delay = i % 3;
            run_stream(32'h4000 + 32'(i) * 32'h100, -1);
            if (got_data.size() > 0) check("vec_word", got_data[0], {184'h0, vecs[i].enc});
            else fail_timeout("vec_word_missing");
            check("vec_total", total_bytes, vecs[i].len);
        end

        // 32 all-zero groups: exactly one zero word at 0x1000.
        stim_q = {};
        repeat (32) stim_q.push_back(64'h0);
        ack_delay = 0;
        run_stream(32'h1000, -1);
        check("zero_write_count", got_data.size(), 1);
        if (got_data.size() > 0) begin
            check("zero_word", got_data[0], 256'h0);
            check("zero_addr", got_addr[0], 32'h1000);
        end
        check("zero_total", total_bytes, 32'd32);

        // Four full groups: 36 bytes spanning two words.
        stim_q = {};
        repeat (4) stim_q.push_back(PAT);
        run_stream(32'h1000, -1);
        check("pat_write_count", got_data.size(), 2);
        if (got_data.size() > 1) begin
            check("pat_word0", got_data[0],
                  256'h04030201FF_0807060504030201FF_0807060504030201FF_0807060504030201FF);
            check("pat_addr0", got_addr[0], 32'h1000);
            check("pat_word1", got_data[1], 256'h08070605);
            check("pat_addr1", got_addr[1], 32'h1020);
        end
        check("pat_total", total_bytes, 32'd36);

        // Slow memory while groups keep arriving.
        stim_q = {};
        repeat (8) stim_q.push_back(PAT);
        ack_delay = 5;
        run_stream(32'h1800, -1);

        // Stray start while busy must not disturb address or count.
        stim_q = {};
        for (int k = 0; k < 10; k++) stim_q.push_back({$urandom, $urandom});
        ack_delay = 1;
        run_stream(32'h3000, 3);

        // Address wraps past the top of the address space.
        stim_q = {};
        repeat (8) stim_q.push_back(PAT);
        ack_delay = 0;
        run_stream(32'hFFFF_FFF0, -1);

        // Reset during an outstanding write.
        ack_delay = 1000;
        start_addr = 32'h1000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 32; k++) send_group(64'h0, 1'b0);
        @(negedge clk);
        check("write_before_rst", mem_bus.mem_write, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        @(negedge clk);
        ack_delay = 0;
        stim_q = {};
        repeat (4) stim_q.push_back(PAT);
        run_stream(32'h2000, -1);
        if (got_addr.size() > 0) check("after_rst_addr0", got_addr[0], 32'h2000);

        // Random streams.
        for (int r = 0; r < 20; r++) begin
            int n;
            n = $urandom_range(1, 40);
            stim_q = {};
            for (int k = 0; k < n; k++) begin
                logic [63:0] g;
                g = '0;
                for (int i = 0; i < 8; i++) begin
                    if ($urandom_range(0, 1) == 1) g[8*i +: 8] = 8'($urandom_range(1, 255));
                end
                stim_q.push_back(g);
            end
            ack_delay = $urandom_range(0, 3);
            run_stream($urandom, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
